// File: rtl/timer_cmd_sequencer.sv
// Command-level sequencer for the 16-bit Avalon interval timer: expands one
// high-level command into timed single-cycle s1 reads/writes and returns a response.
module timer_cmd_sequencer #(
  parameter int unsigned SNAP_ADDR_L = 4,
  parameter int unsigned CTRL_ADDR   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_period,
  input  logic        cmd_cont,
  input  logic        cmd_ie,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata
);

  localparam logic [2:0] CTRL_A   = 3'(CTRL_ADDR);
  localparam logic [2:0] SNAP_L_A = 3'(SNAP_ADDR_L);
  localparam logic [2:0] SNAP_H_A = 3'(SNAP_ADDR_L + 1);
  localparam logic [2:0] STAT_A   = 3'd0;
  localparam logic [2:0] PER_L_A  = 3'd2;
  localparam logic [2:0] PER_H_A  = 3'd3;

  typedef enum logic [1:0] {
    OP_LOAD_START = 2'd0,
    OP_STOP       = 2'd1,
    OP_SNAPSHOT   = 2'd2,
    OP_CLR_STATUS = 2'd3
  } op_e;

  typedef enum logic [3:0] {
    S_IDLE, S_LS_WR, S_STOP_WR, S_SN_WR, S_SN_RDL, S_SN_RDH, S_SN_CAP,
    S_CS_RD, S_CS_WR, S_RSP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [31:0] period_q, period_d;
  logic        cont_q, cont_d;
  logic        ie_q, ie_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [2:0]  addr_q, addr_d;
  logic        cs_q, cs_d;
  logic        write_n_q, write_n_d;
  logic [15:0] wdata_q, wdata_d;

  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    state_d    = state_q;
    step_d     = step_q;
    period_d   = period_q;
    cont_d     = cont_q;
    ie_d       = ie_q;
    rsp_data_d = rsp_data_q;
    addr_d     = '0;
    cs_d       = 1'b0;
    write_n_d  = 1'b1;
    wdata_d    = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rsp_data_d = '0;
          case (cmd_op)
            OP_LOAD_START: begin
              state_d    = S_LS_WR;
              step_d     = '0;
              period_d   = cmd_period;
              cont_d     = cmd_cont;
              ie_d       = cmd_ie;
              rsp_data_d = cmd_period;
            end
            OP_STOP:     state_d = S_STOP_WR;
            OP_SNAPSHOT: state_d = S_SN_WR;
            default:     state_d = S_CS_RD;
          endcase
        end
      end
      S_LS_WR: begin
        if (step_q == 3'd4) state_d = S_RSP;
        else                step_d  = step_q + 3'd1;
      end
      S_STOP_WR: state_d = S_RSP;
      S_SN_WR:   state_d = S_SN_RDL;
      S_SN_RDL:  state_d = S_SN_RDH;
      S_SN_RDH: begin
        rsp_data_d[15:0] = tmr_readdata;
        state_d          = S_SN_CAP;
      end
      S_SN_CAP: begin
        rsp_data_d[31:16] = tmr_readdata;
        state_d           = S_RSP;
      end
      S_CS_RD: state_d = S_CS_WR;
      S_CS_WR: begin
        rsp_data_d = {30'b0, tmr_readdata[1:0]};
        state_d    = S_RSP;
      end
      S_RSP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The bus access registered at this edge belongs to the state being entered.
    case (state_d)
      S_LS_WR: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        case (step_d)
          3'd0:    begin addr_d = CTRL_A;  wdata_d = 16'h0008;         end
          3'd1:    begin addr_d = PER_L_A; wdata_d = period_d[15:0];   end
          3'd2:    begin addr_d = PER_H_A; wdata_d = period_d[31:16];  end
          3'd3:    begin addr_d = STAT_A;  wdata_d = 16'h0000;         end
          default: begin addr_d = CTRL_A;  wdata_d = {12'b0, 2'b01, cont_d, ie_d}; end
        endcase
      end
      S_STOP_WR: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = CTRL_A;
        wdata_d   = {12'b0, 2'b10, cont_d, ie_d};
      end
      S_SN_WR: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = SNAP_L_A;
      end
      S_SN_RDL: begin
        cs_d   = 1'b1;
        addr_d = SNAP_L_A;
      end
      S_SN_RDH: begin
        cs_d   = 1'b1;
        addr_d = SNAP_H_A;
      end
      S_CS_RD: begin
        cs_d   = 1'b1;
        addr_d = STAT_A;
      end
      S_CS_WR: begin
        cs_d      = 1'b1;
        write_n_d = 1'b0;
        addr_d    = STAT_A;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      period_q   <= '0;
      cont_q     <= 1'b0;
      ie_q       <= 1'b0;
      rsp_data_q <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      write_n_q  <= 1'b1;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      period_q   <= period_d;
      cont_q     <= cont_d;
      ie_q       <= ie_d;
      rsp_data_q <= rsp_data_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      write_n_q  <= write_n_d;
      wdata_q    <= wdata_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign rsp_valid      = (state_q == S_RSP);
  assign rsp_data       = rsp_data_q;
  assign tmr_address    = addr_q;
  assign tmr_chipselect = cs_q;
  assign tmr_write_n    = write_n_q;
  assign tmr_writedata  = wdata_q;

endmodule

// File: tb/tb_timer_cmd_sequencer.sv
// Directed bench for timer_cmd_sequencer: a behavioural interval-timer model on
// the s1 side, a table of commands with expected bus traces, plus corner sequences.
module tb_timer_cmd_sequencer;

  localparam logic [1:0] OP_LS = 2'd0, OP_STOP = 2'd1, OP_SN = 2'd2, OP_CLR = 2'd3;

  typedef enum logic [1:0] {A_N, A_R, A_W} kind_e;
  typedef struct packed {
    kind_e       kind;
    logic [2:0]  addr;
    logic [15:0] data;
  } acc_t;
  typedef acc_t [5:0] trace_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] period;
    logic        cont;
    logic        ie;
    logic        preload;
    logic [31:0] preload_val;
    logic        wait_irq;
    logic        early_rdy;
    int          rsp_cyc;
    trace_t      trace;
    logic [31:0] exp_rsp;
    logic        chk_after;
    logic        exp_run;
    logic        exp_irq;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_period;
  logic        cmd_cont, cmd_ie;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata, tmr_readdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_cmd_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ie(cmd_ie),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata)
  );

  // Interval-timer model: status {run,to} at 0, control at 1, period at 2/3,
  // snapshot at 4/5; readdata follows the address with one cycle of latency.
  logic [3:0]  m_ctrl = '0;
  logic [15:0] m_per_l = '0, m_per_h = '0, m_rd = '0;
  logic [31:0] m_cnt = '0, m_snap = '0;
  logic        m_run = 1'b0, m_to = 1'b0;
  logic        m_irq;
  logic        cnt_load = 1'b0;
  logic [31:0] cnt_load_val = '0;

  assign m_irq        = m_to & m_ctrl[0];
  assign tmr_readdata = m_rd;

  always @(posedge clk) begin
    case (tmr_address)
      3'd0:    m_rd <= {14'b0, m_run, m_to};
      3'd1:    m_rd <= {12'b0, m_ctrl};
      3'd2:    m_rd <= m_per_l;
      3'd3:    m_rd <= m_per_h;
      3'd4:    m_rd <= m_snap[15:0];
      3'd5:    m_rd <= m_snap[31:16];
      default: m_rd <= '0;
    endcase
    if (cnt_load) m_cnt <= cnt_load_val;
    else if (m_run) begin
      if (m_cnt == 32'd0) begin
        m_to  <= 1'b1;
        m_cnt <= {m_per_h, m_per_l};
        if (!m_ctrl[1]) m_run <= 1'b0;
      end else m_cnt <= m_cnt - 32'd1;
    end
    if (tmr_chipselect && !tmr_write_n) begin
      case (tmr_address)
        3'd0: m_to <= 1'b0;
        3'd1: begin
          m_ctrl <= tmr_writedata[3:0];
          if (tmr_writedata[2]) begin
            m_run <= 1'b1;
            m_cnt <= {m_per_h, m_per_l};
          end
          if (tmr_writedata[3]) m_run <= 1'b0;
        end
        3'd2: m_per_l <= tmr_writedata;
        3'd3: m_per_h <= tmr_writedata;
        3'd4, 3'd5: m_snap <= m_cnt;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic acc_t acc_w(input logic [2:0] a, input logic [15:0] d);
    return '{kind: A_W, addr: a, data: d};
  endfunction
  function automatic acc_t acc_r(input logic [2:0] a);
    return '{kind: A_R, addr: a, data: 16'h0};
  endfunction
  function automatic acc_t acc_n();
    return '{kind: A_N, addr: 3'd0, data: 16'h0};
  endfunction
  function automatic trace_t seq(input acc_t c1, c2, c3, c4, c5, c6);
    trace_t t;
    t[0] = c1; t[1] = c2; t[2] = c3; t[3] = c4; t[4] = c5; t[5] = c6;
    return t;
  endfunction

  task automatic check_bus(input string name, input acc_t a);
    case (a.kind)
      A_W:     check(name, {11'b0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
                     {11'b0, 2'b10, a.addr, a.data});
      A_R:     check(name, {27'b0, tmr_chipselect, tmr_write_n, tmr_address}, {27'b0, 2'b11, a.addr});
      default: check(name, {30'b0, tmr_chipselect, tmr_write_n}, 32'b01);
    endcase
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    if (v.preload) begin
      @(negedge clk);
      cnt_load_val = v.preload_val;
      cnt_load     = 1'b1;
      @(posedge clk);
      #1 cnt_load = 1'b0;
    end
    if (v.wait_irq) begin
      n = 0;
      while (!m_irq && n < 50) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("v%0d irq_fired", idx), {31'b0, m_irq}, 32'd1);
    end
    @(negedge clk);
    check($sformatf("v%0d cmd_ready_idle", idx), {31'b0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_op     = v.op;
    cmd_period = v.period;
    cmd_cont   = v.cont;
    cmd_ie     = v.ie;
    if (v.early_rdy) rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_period = ~v.period;
    cmd_cont   = ~v.cont;
    cmd_ie     = ~v.ie;
    for (int k = 1; k < v.rsp_cyc; k++) begin
      @(negedge clk);
      check_bus($sformatf("v%0d c%0d bus", idx, k), v.trace[k-1]);
      check($sformatf("v%0d c%0d busy", idx, k), {30'b0, rsp_valid, cmd_ready}, 32'd0);
    end
    @(negedge clk);
    check($sformatf("v%0d rsp_valid", idx), {31'b0, rsp_valid}, 32'd1);
    check($sformatf("v%0d rsp_data", idx), rsp_data, v.exp_rsp);
    check_bus($sformatf("v%0d rsp_bus", idx), acc_n());
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d back_idle", idx), {30'b0, rsp_valid, cmd_ready}, 32'b01);
    if (v.chk_after)
      check($sformatf("v%0d timer_run_irq", idx), {30'b0, m_run, m_irq}, {30'b0, v.exp_run, v.exp_irq});
  endtask

  vec_t vecs[8];
  vec_t stop_v;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{op: OP_LS, period: 32'h0001_86A0, cont: 1'b1, ie: 1'b1, preload: 1'b0, preload_val: 32'h0,
                wait_irq: 1'b0, early_rdy: 1'b0, rsp_cyc: 6,
                trace: seq(acc_w(1, 16'h0008), acc_w(2, 16'h86A0), acc_w(3, 16'h0001), acc_w(0, 16'h0000), acc_w(1, 16'h0007), acc_n()),
                exp_rsp: 32'h0001_86A0, chk_after: 1'b1, exp_run: 1'b1, exp_irq: 1'b0};
    vecs[1] = '{op: OP_CLR, period: 32'h0, cont: 1'b0, ie: 1'b0, preload: 1'b1, preload_val: 32'd3,
                wait_irq: 1'b1, early_rdy: 1'b0, rsp_cyc: 3,
                trace: seq(acc_r(0), acc_w(0, 16'h0000), acc_n(), acc_n(), acc_n(), acc_n()),
                exp_rsp: 32'h0000_0003, chk_after: 1'b1, exp_run: 1'b1, exp_irq: 1'b0};
    vecs[2] = '{op: OP_STOP, period: 32'hDEAD_BEEF, cont: 1'b0, ie: 1'b0, preload: 1'b0, preload_val: 32'h0,
                wait_irq: 1'b0, early_rdy: 1'b0, rsp_cyc: 2,
                trace: seq(acc_w(1, 16'h000B), acc_n(), acc_n(), acc_n(), acc_n(), acc_n()),
                exp_rsp: 32'h0, chk_after: 1'b1, exp_run: 1'b0, exp_irq: 1'b0};
    vecs[3] = '{op: OP_SN, period: 32'h0, cont: 1'b0, ie: 1'b0, preload: 1'b1, preload_val: 32'h0002_1234,
                wait_irq: 1'b0, early_rdy: 1'b0, rsp_cyc: 5,
                trace: seq(acc_w(4, 16'h0000), acc_r(4), acc_r(5), acc_n(), acc_n(), acc_n()),
                exp_rsp: 32'h0002_1234, chk_after: 1'b1, exp_run: 1'b0, exp_irq: 1'b0};
    vecs[4] = '{op: OP_LS, period: 32'h0000_0010, cont: 1'b0, ie: 1'b0, preload: 1'b0, preload_val: 32'h0,
                wait_irq: 1'b0, early_rdy: 1'b0, rsp_cyc: 6,
                trace: seq(acc_w(1, 16'h0008), acc_w(2, 16'h0010), acc_w(3, 16'h0000), acc_w(0, 16'h0000), acc_w(1, 16'h0004), acc_n()),
                exp_rsp: 32'h0000_0010, chk_after: 1'b1, exp_run: 1'b1, exp_irq: 1'b0};
    vecs[5] = '{op: OP_STOP, period: 32'h0, cont: 1'b1, ie: 1'b1, preload: 1'b0, preload_val: 32'h0,
                wait_irq: 1'b0, early_rdy: 1'b1, rsp_cyc: 2,
                trace: seq(acc_w(1, 16'h0008), acc_n(), acc_n(), acc_n(), acc_n(), acc_n()),
                exp_rsp: 32'h0, chk_after: 1'b1, exp_run: 1'b0, exp_irq: 1'b0};
    vecs[6] = '{op: OP_CLR, period: 32'h0, cont: 1'b0, ie: 1'b0, preload: 1'b0, preload_val: 32'h0,
                wait_irq: 1'b0, early_rdy: 1'b1, rsp_cyc: 3,
                trace: seq(acc_r(0), acc_w(0, 16'h0000), acc_n(), acc_n(), acc_n(), acc_n()),
                exp_rsp: 32'h0, chk_after: 1'b0, exp_run: 1'b0, exp_irq: 1'b0};
    vecs[7] = '{op: OP_SN, period: 32'h0, cont: 1'b0, ie: 1'b0, preload: 1'b1, preload_val: 32'hFFFF_0000,
                wait_irq: 1'b0, early_rdy: 1'b0, rsp_cyc: 5,
                trace: seq(acc_w(4, 16'h0000), acc_r(4), acc_r(5), acc_n(), acc_n(), acc_n()),
                exp_rsp: 32'hFFFF_0000, chk_after: 1'b0, exp_run: 1'b0, exp_irq: 1'b0};
    stop_v = vecs[5];
    stop_v.early_rdy = 1'b0;

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_period = '0;
    cmd_cont = 1'b0; cmd_ie = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hs", {30'b0, cmd_ready, rsp_valid}, 32'b10);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_bus", {11'b0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {11'b0, 2'b01, 19'h0});
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a LOAD_START, then STOP must see cleared shadow bits.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_LS; cmd_period = 32'h1234_5678; cmd_cont = 1'b1; cmd_ie = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_bus("rst_c1 bus", acc_w(1, 16'h0008));
    @(negedge clk);
    check_bus("rst_c2 bus", acc_w(2, 16'h5678));
    @(negedge clk);
    check_bus("rst_c3 bus", acc_w(3, 16'h1234));
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_hs", {30'b0, cmd_ready, rsp_valid}, 32'b10);
    check("midrst_rsp_data", rsp_data, 32'h0);
    check("midrst_bus", {11'b0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}, {11'b0, 2'b01, 19'h0});
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_quiet", {30'b0, rsp_valid, tmr_chipselect}, 32'd0);
    end
    run_vec(8, stop_v);

    // Response held under back-pressure while a new command is offered.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_STOP;
    @(posedge clk);
    #1 cmd_op = OP_LS;
    cmd_period = 32'hA5A5_5A5A;
    @(negedge clk);
    check_bus("hold_c1 bus", acc_w(1, 16'h0008));
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check($sformatf("hold_%0d state", k), {29'b0, rsp_valid, cmd_ready, tmr_chipselect}, 32'b100);
      check($sformatf("hold_%0d data", k), rsp_data, 32'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("hold_release_idle", {30'b0, rsp_valid, cmd_ready}, 32'b01);
    cmd_op = OP_CLR;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check_bus("next_c1 bus", acc_r(0));
    @(negedge clk);
    check_bus("next_c2 bus", acc_w(0, 16'h0000));
    @(negedge clk);
    check("next_rsp", {31'b0, rsp_valid}, 32'd1);
    check("next_rsp_data", rsp_data, 32'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check("final_idle", {30'b0, rsp_valid, cmd_ready}, 32'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
